alu_mc: RTL

Parametrised multi-cycle integer ALU for the EX stage of the MIPS core. It supersedes the single-cycle ALU and adds the following:
- full-range shifts, including SRA and the variable shifts SLLV/SRLV/SRAV;
- SLTU/SLTIU;
- an XLEN parameter;
- valid/ready handshakes on input and output, so the pipeline can stall on long shifts.

Shifts run on an iterative shifter at SHIFT_STEP bits per cycle. Every other operation completes in one cycle.

---
 rtl/alu_pkg.sv | 12 +
 rtl/mips_inst_pkg.sv | 31 +++
 rtl/alu_shift_iter.sv | 58 +++++
 rtl/alu_mc.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU decode classes, logic/shift sub-selects and FSM state encoding.
package alu_pkg;
  typedef enum logic [2:0] {
    OP_ADD, OP_SUB, OP_LOGI, OP_SLT, OP_SLTU, OP_LUI, OP_SHIFT, OP_ERR
  } op_cls_e;

  typedef enum logic [1:0] {LOGI_AND, LOGI_OR, LOGI_XOR, LOGI_NOR} logi_e;

  typedef enum logic [1:0] {SH_LL, SH_RL, SH_RA} sh_kind_e;

  typedef enum logic {ST_IDLE, ST_SHIFT} state_e;
endpackage

// File: rtl/mips_inst_pkg.sv
// MIPS instruction field encodings (opcode and R-type funct) used by the EX stage.
package mips_inst_pkg;
  localparam logic [5:0] INST_R     = 6'h00;
  localparam logic [5:0] INST_ADDI  = 6'h08;
  localparam logic [5:0] INST_ADDIU = 6'h09;
  localparam logic [5:0] INST_SLTI  = 6'h0A;
  localparam logic [5:0] INST_SLTIU = 6'h0B;
  localparam logic [5:0] INST_ANDI  = 6'h0C;
  localparam logic [5:0] INST_ORI   = 6'h0D;
  localparam logic [5:0] INST_XORI  = 6'h0E;
  localparam logic [5:0] INST_LUI   = 6'h0F;
  localparam logic [5:0] INST_LW    = 6'h23;
  localparam logic [5:0] INST_SW    = 6'h2B;

  localparam logic [5:0] FUNCT_SLL  = 6'h00;
  localparam logic [5:0] FUNCT_SRL  = 6'h02;
  localparam logic [5:0] FUNCT_SRA  = 6'h03;
  localparam logic [5:0] FUNCT_SLLV = 6'h04;
  localparam logic [5:0] FUNCT_SRLV = 6'h06;
  localparam logic [5:0] FUNCT_SRAV = 6'h07;
  localparam logic [5:0] FUNCT_ADD  = 6'h20;
  localparam logic [5:0] FUNCT_ADDU = 6'h21;
  localparam logic [5:0] FUNCT_SUB  = 6'h22;
  localparam logic [5:0] FUNCT_SUBU = 6'h23;
  localparam logic [5:0] FUNCT_AND  = 6'h24;
  localparam logic [5:0] FUNCT_OR   = 6'h25;
  localparam logic [5:0] FUNCT_XOR  = 6'h26;
  localparam logic [5:0] FUNCT_NOR  = 6'h27;
  localparam logic [5:0] FUNCT_SLT  = 6'h2A;
  localparam logic [5:0] FUNCT_SLTU = 6'h2B;
endpackage

// File: rtl/alu_shift_iter.sv
// Iterative shifter: up to SHIFT_STEP bits per edge, first step taken on the start edge.
module alu_shift_iter
  import alu_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int SHIFT_STEP = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      kill,
  input  logic                      start,
  input  logic                      run,
  input  logic [1:0]                kind,
  input  logic [XLEN-1:0]           din,
  input  logic [$clog2(XLEN)-1:0]   amt,
  output logic                      done,
  output logic [XLEN-1:0]           result
);
  localparam int SW = $clog2(XLEN);
  localparam logic [SW:0] STEP = (SW+1)'(SHIFT_STEP);

  logic [XLEN-1:0] r_sh;
  logic [SW:0]     r_rem;
  logic [1:0]      r_kind;

  logic [XLEN-1:0] w_src;
  logic [SW:0]     w_left, w_step;
  logic [1:0]      w_kind;

  // On the start edge the operands come straight from the decode, afterwards from the registers.
  assign w_src  = start ? din : r_sh;
  assign w_kind = start ? kind : r_kind;
  assign w_left = start ? {1'b0, amt} : r_rem;
  assign w_step = (w_left > STEP) ? STEP : w_left;
  assign done   = (start || run) && (w_left <= STEP);

  always_comb begin
    case (w_kind)
      SH_RL:   result = w_src >> w_step;
      SH_RA:   result = XLEN'($signed(w_src) >>> w_step);
      default: result = w_src << w_step;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sh   <= '0;
      r_rem  <= '0;
      r_kind <= '0;
    end else if (kill) begin
      r_rem  <= '0;
    end else if (start || run) begin
      r_sh   <= result;
      r_rem  <= w_left - w_step;
      r_kind <= w_kind;
    end
  end
endmodule

// File: rtl/alu_mc.sv
// Multi-cycle EX-stage integer ALU with valid/ready handshakes and an iterative shifter.
module alu_mc
  import alu_pkg::*;
  import mips_inst_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int SHIFT_STEP = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    kill,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [5:0]              opcode,
  input  logic [5:0]              funct,
  input  logic [$clog2(XLEN)-1:0] shamt,
  input  logic [15:0]             imm,
  input  logic [XLEN-1:0]         rrs,
  input  logic [XLEN-1:0]         rrt,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [XLEN-1:0]         rslt,
  output logic                    out_err
);
  localparam int SW = $clog2(XLEN);

  state_e          r_state;
  logic            r_out_valid;
  logic [XLEN-1:0] r_rslt;
  logic            r_err;

  op_cls_e         w_cls;
  logi_e           w_logi;
  sh_kind_e        w_shk;
  logic [XLEN-1:0] w_b, w_val, w_sext, w_zext, w_sh_res;
  logic [SW-1:0]   w_amt;
  logic            w_accept, w_sh_start, w_sh_run, w_sh_done;

  assign w_sext = {{(XLEN-16){imm[15]}}, imm};
  assign w_zext = {{(XLEN-16){1'b0}}, imm};

  assign in_ready   = rst_n && (r_state == ST_IDLE) && !kill && (!r_out_valid || out_ready);
  assign w_accept   = in_valid && in_ready;
  assign w_sh_start = w_accept && (w_cls == OP_SHIFT);
  assign w_sh_run   = (r_state == ST_SHIFT);

  always_comb begin
    w_cls  = OP_ERR;
    w_logi = LOGI_AND;
    w_shk  = SH_LL;
    w_b    = w_sext;
    w_amt  = shamt;
    case (opcode)
      INST_R: begin
        w_b = rrt;
        case (funct)
          FUNCT_ADD, FUNCT_ADDU: w_cls = OP_ADD;
          FUNCT_SUB, FUNCT_SUBU: w_cls = OP_SUB;
          FUNCT_AND:  begin w_cls = OP_LOGI;  w_logi = LOGI_AND; end
          FUNCT_OR:   begin w_cls = OP_LOGI;  w_logi = LOGI_OR;  end
          FUNCT_XOR:  begin w_cls = OP_LOGI;  w_logi = LOGI_XOR; end
          FUNCT_NOR:  begin w_cls = OP_LOGI;  w_logi = LOGI_NOR; end
          FUNCT_SLT:  w_cls = OP_SLT;
          FUNCT_SLTU: w_cls = OP_SLTU;
          FUNCT_SLL:  begin w_cls = OP_SHIFT; w_shk = SH_LL; end
          FUNCT_SRL:  begin w_cls = OP_SHIFT; w_shk = SH_RL; end
          FUNCT_SRA:  begin w_cls = OP_SHIFT; w_shk = SH_RA; end
          FUNCT_SLLV: begin w_cls = OP_SHIFT; w_shk = SH_LL; w_amt = rrs[SW-1:0]; end
          FUNCT_SRLV: begin w_cls = OP_SHIFT; w_shk = SH_RL; w_amt = rrs[SW-1:0]; end
          FUNCT_SRAV: begin w_cls = OP_SHIFT; w_shk = SH_RA; w_amt = rrs[SW-1:0]; end
          default: ;
        endcase
      end
      INST_ADDI, INST_ADDIU, INST_LW, INST_SW: w_cls = OP_ADD;
      INST_SLTI:  w_cls = OP_SLT;
      INST_SLTIU: w_cls = OP_SLTU;
      INST_ANDI:  begin w_cls = OP_LOGI; w_logi = LOGI_AND; w_b = w_zext; end
      INST_ORI:   begin w_cls = OP_LOGI; w_logi = LOGI_OR;  w_b = w_zext; end
      INST_XORI:  begin w_cls = OP_LOGI; w_logi = LOGI_XOR; w_b = w_zext; end
      INST_LUI:   w_cls = OP_LUI;
      default: ;
    endcase
  end

  always_comb begin
    w_val = '0;
    case (w_cls)
      OP_ADD:  w_val = rrs + w_b;
      OP_SUB:  w_val = rrs - w_b;
      OP_LOGI: begin
        case (w_logi)
          LOGI_AND: w_val = rrs & w_b;
          LOGI_OR:  w_val = rrs | w_b;
          LOGI_XOR: w_val = rrs ^ w_b;
          default:  w_val = ~(rrs | w_b);
        endcase
      end
      OP_SLT:   w_val = {{(XLEN-1){1'b0}}, $signed(rrs) < $signed(w_b)};
      OP_SLTU:  w_val = {{(XLEN-1){1'b0}}, rrs < w_b};
      OP_LUI:   w_val = w_sext << 16;
      OP_SHIFT: w_val = w_sh_res;
      default:  w_val = '0;
    endcase
  end

  alu_shift_iter #(.XLEN(XLEN), .SHIFT_STEP(SHIFT_STEP)) u_shift (
    .clk    (clk),
    .rst_n  (rst_n),
    .kill   (kill),
    .start  (w_sh_start),
    .run    (w_sh_run),
    .kind   (w_shk),
    .din    (rrt),
    .amt    (w_amt),
    .done   (w_sh_done),
    .result (w_sh_res)
  );

  // An accept always implies the held result (if any) is consumed on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_out_valid <= 1'b0;
      r_rslt      <= '0;
      r_err       <= 1'b0;
    end else if (kill) begin
      r_state     <= ST_IDLE;
      r_out_valid <= 1'b0;
    end else if (w_sh_start && !w_sh_done) begin
      r_state     <= ST_SHIFT;
      r_out_valid <= 1'b0;
    end else if (w_accept) begin
      r_rslt      <= w_val;
      r_err       <= (w_cls == OP_ERR);
      r_out_valid <= 1'b1;
    end else if (w_sh_run && w_sh_done) begin
      r_state     <= ST_IDLE;
      r_rslt      <= w_sh_res;
      r_err       <= 1'b0;
      r_out_valid <= 1'b1;
    end else if (r_out_valid && out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid = r_out_valid;
  assign rslt      = r_rslt;
  assign out_err   = r_err;
endmodule
